// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// Holds the FSM state encoding and the word geometry.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WRITE,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Word stream in, byte write bus out.
// The loader uses the slave side; the feeder/memory uses master.
interface imem_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        mem_we;
    logic [63:0] mem_adr;
    logic [7:0]  mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  mem_we,
        input  mem_adr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output mem_we,
        output mem_adr,
        output mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction
// memory, little-endian, one byte per cycle with bounds checking.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned SIZE = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      base_adr,
    imem_loader_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      word_count
);

    localparam logic [64:0] LIM = 65'(SIZE) - 65'd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [63:0]       ptr_q, ptr_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [64:0]       end_adr;
    logic              we;

    // 65-bit sum so a pointer near 2^64 cannot wrap past the check
    assign end_adr = {1'b0, ptr_q} + 65'(BYTES_PER_WORD - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    if (base_adr[1:0] != 2'b00) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        ptr_d   = base_adr;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.in_valid) begin
                    word_d = bus.in_data;
                    last_d = bus.in_last;
                    idx_d  = '0;
                    if (end_adr > LIM) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    ptr_d   = ptr_q + 64'(BYTES_PER_WORD);
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    state_d = last_q ? DONE : WAIT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Reset kills the strobe in the same cycle so the edge that
    // samples rst never commits a byte.
    assign we            = (state_q == WRITE) && !rst;
    assign bus.mem_we    = we;
    assign bus.mem_adr   = we ? ptr_q + 64'(idx_q) : '0;
    assign bus.mem_wdata = we ? word_q[{idx_q, 3'b000} +: 8] : '0;
    assign bus.in_ready  = (state_q == WAIT);

    assign busy       = (state_q == WAIT) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign error      = err_q;
    assign word_count = cnt_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter SIZE, default 256, byte capacity of the target instruction memory.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a load session; sampled only in IDLE or ERR.
REQ-005 base_adr  input  64  starting byte address, sampled with start.
REQ-006 in_valid  input  1  in_data/in_last valid.
REQ-007 in_ready  output  1  loader can accept a word.
REQ-008 in_data  input  32  instruction word to store.
REQ-009 in_last  input  1  marks the final word of the program.
REQ-010 mem_we  output  1  byte write strobe to the instruction memory.
REQ-011 mem_adr  output  64  byte address of the current write.
REQ-012 mem_wdata  output  8  byte to write.
REQ-013 busy  output  1  high in WAIT or WRITE.
REQ-014 done  output  1  one-cycle pulse when a session completes.
REQ-015 error  output  1  sticky fault flag.
REQ-016 word_count  output  16  words fully written in the current session.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT, WRITE, DONE and ERR.
REQ-018 IDLE/ERR + start: if base_adr[1:0]!=0 -> ERR with error=1; else ptr<=base_adr, word_count<=0, error<=0 -> WAIT.
REQ-019 start SHALL be ignored in WAIT, WRITE and DONE.
REQ-020 in_ready SHALL be 1 only in WAIT; a word is accepted on in_valid&in_ready, capturing in_data and in_last.
REQ-021 If ptr+3 > SIZE-1 at acceptance (64-bit compare, no wrap), the block SHALL perform no writes and go to ERR with error=1.
REQ-022 Otherwise the block SHALL enter WRITE for exactly 4 cycles, byte_idx 0..3: mem_we=1, mem_adr=ptr+byte_idx, mem_wdata=word[8*byte_idx+7 : 8*byte_idx] (little-endian).
REQ-023 The first byte write SHALL occur in the cycle after acceptance; steady-state throughput is 1 word per 5 cycles.
REQ-024 After byte 3: ptr<=ptr+4 and word_count<=word_count+1 (saturating at 0xFFFF); last -> DONE, else -> WAIT.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 In ERR, error SHALL stay 1 until rst or a valid start.
REQ-027 mem_we SHALL be 0 in every state except WRITE; mem_adr and mem_wdata SHALL be 0 when mem_we=0.
REQ-028 Words with in_valid=0 SHALL be waited for indefinitely in WAIT without timeout.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-WRITE, with no further byte writes after that edge.
REQ-030 Reset values: in_ready=0, mem_we=0, mem_adr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0, ptr=0.

Structure
REQ-031 The package imem_loader_pkg SHALL hold the state enum and BYTES_PER_WORD=4.
REQ-032 The block SHALL be a single module with no sub-modules; the byte lane mux is inline.

Verification
REQ-033 start, base_adr=0; words 0xE5031F8B, 0xA40040F8 (last) -> writes 8B,1F,03,E5 at 0..3, then F8,40,00,A4 at 4..7; done pulses once; word_count=2.
REQ-034 in_valid held high over 4 words -> in_ready=0 during each WRITE; exactly 16 mem_we cycles, contiguous addresses 0..15.
REQ-035 SIZE=256, base_adr=252, one word -> writes 252..255 OK; base_adr=254 -> error at start (misaligned); base_adr=256 -> error on acceptance, zero writes.
REQ-036 rst asserted on the 2nd WRITE cycle -> only byte 0 written, then all outputs at reset values the next cycle.
REQ-037 start pulsed during WRITE -> ignored; a new start from ERR clears error and loads from the new base_adr.
